// File: rtl/tmr_recovery_sequencer_if.sv
// Bundle between the TMR voter/status logic and the recovery sequencer.
//   enable        : allow qualification of new faults
//   fault_flags   : per-lane mismatch flags from the voter
//   disagreement  : voter any-mismatch flag
//   clear_failed  : pulse clearing retired flags and fault counters
//   lane_rst_n    : active-low per-lane core resets
//   busy          : sequencer not idle
//   active_lane   : lane under recovery, 3 when idle
//   lane_failed   : sticky retired-lane flags
//   fault_cnt     : per-lane qualified-fault counters (lane i at [i*CNT_W +: CNT_W])
//   recover_ok    : pulse on successful recovery
//   recover_fail  : pulse when a lane is retired
// master drives the voter-side inputs; slave is the sequencer.
interface tmr_recovery_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic               enable;
  logic [2:0]         fault_flags;
  logic               disagreement;
  logic               clear_failed;
  logic [2:0]         lane_rst_n;
  logic               busy;
  logic [1:0]         active_lane;
  logic [2:0]         lane_failed;
  logic [3*CNT_W-1:0] fault_cnt;
  logic               recover_ok;
  logic               recover_fail;

  modport master (
    output enable, fault_flags, disagreement, clear_failed,
    input  lane_rst_n, busy, active_lane, lane_failed, fault_cnt,
           recover_ok, recover_fail
  );

  modport slave (
    input  enable, fault_flags, disagreement, clear_failed,
    output lane_rst_n, busy, active_lane, lane_failed, fault_cnt,
           recover_ok, recover_fail
  );
endinterface

// File: rtl/tmr_recovery_sequencer.sv
// Recovery sequencer for a triple-modular-redundant core.
// Qualifies a persistent single-lane fault from the voter flags, holds that
// lane's core in reset, waits for it to re-agree with the majority, retries a
// bounded number of times and finally retires the lane.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : tmr_recovery_sequencer_if slave (voter inputs, lane resets, status)
module tmr_recovery_sequencer #(
  parameter int unsigned PERSIST_CYCLES = 4,
  parameter int unsigned RESET_HOLD     = 16,
  parameter int unsigned SETTLE_MAX     = 64,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tmr_recovery_sequencer_if.slave   bus
);

  // One shared timer serves the persist, hold and settle phases.
  localparam int unsigned TMAX_A = (RESET_HOLD > SETTLE_MAX) ? RESET_HOLD : SETTLE_MAX;
  localparam int unsigned TMAX   = (TMAX_A > PERSIST_CYCLES) ? TMAX_A : PERSIST_CYCLES;
  localparam int unsigned TW     = $clog2(TMAX + 1);
  localparam int unsigned RW     = $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, QUALIFY, HOLD, SETTLE} state_e;

  state_e             state_q;
  logic [2:0]         flags_q;       // latched one-hot of the lane under recovery
  logic [TW-1:0]      timer_q;
  logic [RW-1:0]      retry_q;
  logic [2:0]         lane_rst_n_q;
  logic               busy_q;
  logic [1:0]         active_q;
  logic [2:0]         lane_failed_q;
  logic [3*CNT_W-1:0] fault_cnt_q;
  logic               ok_q;
  logic               fail_q;

  logic               cand_valid;
  logic [1:0]         cand_lane;

  // A candidate is exactly one flag set on a lane that has not been retired.
  always_comb begin
    cand_valid = 1'b0;
    cand_lane  = 2'd3;
    case (bus.fault_flags)
      3'b001: begin cand_lane = 2'd0; cand_valid = !lane_failed_q[0]; end
      3'b010: begin cand_lane = 2'd1; cand_valid = !lane_failed_q[1]; end
      3'b100: begin cand_lane = 2'd2; cand_valid = !lane_failed_q[2]; end
      default: ;
    endcase
  end

  // Saturating increment of one lane's counter.
  function automatic logic [3*CNT_W-1:0] bump(input logic [3*CNT_W-1:0] cnt,
                                              input logic [1:0]         lane);
    logic [3*CNT_W-1:0] r;
    r = cnt;
    for (int unsigned i = 0; i < 3; i++) begin
      if (2'(i) == lane && r[i*CNT_W +: CNT_W] != '1)
        r[i*CNT_W +: CNT_W] = r[i*CNT_W +: CNT_W] + CNT_ONE;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      flags_q       <= '0;
      timer_q       <= '0;
      retry_q       <= '0;
      lane_rst_n_q  <= '1;
      busy_q        <= 1'b0;
      active_q      <= 2'd3;
      lane_failed_q <= '0;
      fault_cnt_q   <= '0;
      ok_q          <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      ok_q   <= 1'b0;
      fail_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.enable && cand_valid) begin
            flags_q  <= bus.fault_flags;
            busy_q   <= 1'b1;
            active_q <= cand_lane;
            timer_q  <= TW'(1);
            if (PERSIST_CYCLES == 1) begin
              state_q      <= HOLD;
              lane_rst_n_q <= ~bus.fault_flags;
              fault_cnt_q  <= bump(fault_cnt_q, cand_lane);
              retry_q      <= '0;
            end else begin
              state_q <= QUALIFY;
            end
          end
        end

        QUALIFY: begin
          if (bus.fault_flags == flags_q) begin
            // timer_q holds the samples seen so far; this one completes the run.
            if (timer_q == TW'(PERSIST_CYCLES - 1)) begin
              state_q      <= HOLD;
              lane_rst_n_q <= ~flags_q;
              fault_cnt_q  <= bump(fault_cnt_q, active_q);
              retry_q      <= '0;
              timer_q      <= TW'(1);
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end else begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            active_q <= 2'd3;
            timer_q  <= '0;
          end
        end

        HOLD: begin
          if (timer_q == TW'(RESET_HOLD)) begin
            state_q      <= SETTLE;
            lane_rst_n_q <= '1;
            timer_q      <= TW'(1);
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        SETTLE: begin
          // Success is tested first so it wins over a coincident timeout.
          if ((bus.fault_flags & flags_q) == '0 && !bus.disagreement) begin
            ok_q     <= 1'b1;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            active_q <= 2'd3;
            timer_q  <= '0;
          end else if (timer_q == TW'(SETTLE_MAX)) begin
            if (retry_q == RW'(MAX_RETRIES - 1)) begin
              retry_q       <= RW'(MAX_RETRIES);
              lane_failed_q <= lane_failed_q | flags_q;
              fail_q        <= 1'b1;
              state_q       <= IDLE;
              busy_q        <= 1'b0;
              active_q      <= 2'd3;
              timer_q       <= '0;
            end else begin
              retry_q      <= retry_q + RW'(1);
              state_q      <= HOLD;
              lane_rst_n_q <= ~flags_q;
              timer_q      <= TW'(1);
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase

      // Placed last so a coincident set/increment above is overridden.
      if (bus.clear_failed) begin
        lane_failed_q <= '0;
        fault_cnt_q   <= '0;
      end
    end
  end

  assign bus.lane_rst_n   = lane_rst_n_q;
  assign bus.busy         = busy_q;
  assign bus.active_lane  = active_q;
  assign bus.lane_failed  = lane_failed_q;
  assign bus.fault_cnt    = fault_cnt_q;
  assign bus.recover_ok   = ok_q;
  assign bus.recover_fail = fail_q;

endmodule

// File: tb/tb_tmr_recovery_sequencer.sv
// Directed bench for tmr_recovery_sequencer with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tmr_recovery_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tmr_recovery_sequencer_if #(.CNT_W(8)) bus_if ();

  tmr_recovery_sequencer #(
    .PERSIST_CYCLES (4),
    .RESET_HOLD     (16),
    .SETTLE_MAX     (64),
    .MAX_RETRIES    (3),
    .CNT_W          (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int vectors     = 0;
  int miscompares = 0;
  int low_cnt, ok_cnt, ok_idx, first_low, fail_cnt, fail_idx, bad_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (bus_if.busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle", {31'd0, bus_if.busy}, 32'd0);
  endtask

  task automatic run_seq(input logic [2:0] oh);
    bus_if.fault_flags = oh;
    cyc(4);
    bus_if.fault_flags = 3'b000;
    wait_idle(40);
    cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n                = 1'b0;
    bus_if.enable        = 1'b1;
    bus_if.fault_flags   = 3'b000;
    bus_if.disagreement  = 1'b0;
    bus_if.clear_failed  = 1'b0;
    cyc(3);
    check("rst_lane_rst_n", bus_if.lane_rst_n, 3'b111);
    check("rst_busy", bus_if.busy, 0);
    check("rst_active", bus_if.active_lane, 2'd3);
    check("rst_failed", bus_if.lane_failed, 0);
    check("rst_cnt", bus_if.fault_cnt, 0);
    check("rst_ok_fail", {bus_if.recover_ok, bus_if.recover_fail}, 0);
    rst_n = 1'b1;
    cyc(2);

    // Lane 1 qualified after 4 samples, 16-cycle hold, recovers at once.
    bus_if.fault_flags = 3'b010;
    cyc(1);
    check("t1_busy_q", bus_if.busy, 1);
    check("t1_active", bus_if.active_lane, 2'd1);
    cyc(2);
    check("t1_no_rst_yet", bus_if.lane_rst_n, 3'b111);
    low_cnt = 0; ok_cnt = 0; ok_idx = 0; first_low = 0; bad_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus_if.fault_flags = 3'b000;
      if (bus_if.lane_rst_n == 3'b101) begin
        low_cnt++;
        if (first_low == 0) first_low = i;
        if (!bus_if.busy || bus_if.active_lane != 2'd1) bad_cnt++;
      end else if (bus_if.lane_rst_n != 3'b111) bad_cnt++;
      if (bus_if.recover_ok) begin ok_cnt++; ok_idx = i; end
    end
    check("t1_first_low", first_low, 1);
    check("t1_low_cycles", low_cnt, 16);
    check("t1_status_bad", bad_cnt, 0);
    check("t1_ok_cnt", ok_cnt, 1);
    check("t1_ok_idx", ok_idx, 18);
    check("t1_fault_cnt", bus_if.fault_cnt, 24'h000100);
    check("t1_idle", {bus_if.busy, bus_if.active_lane}, 3'b011);

    // Transient: 3 samples then clear.
    bus_if.fault_flags = 3'b001;
    cyc(3);
    check("t2_busy_q", bus_if.busy, 1);
    bus_if.fault_flags = 3'b000;
    bad_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_if.lane_rst_n != 3'b111) bad_cnt++;
    end
    check("t2_no_rst", bad_cnt, 0);
    check("t2_idle", bus_if.busy, 0);
    check("t2_fault_cnt", bus_if.fault_cnt, 24'h000100);

    // enable low: nothing qualifies.
    bus_if.enable = 1'b0;
    bus_if.fault_flags = 3'b100;
    bad_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_if.busy || bus_if.lane_rst_n != 3'b111) bad_cnt++;
    end
    check("ten_no_action", bad_cnt, 0);
    bus_if.enable = 1'b1;
    bus_if.fault_flags = 3'b000;
    cyc(1);

    // Lane 2: flags clear 5 cycles after release, disagreement delays success.
    bus_if.fault_flags = 3'b100;
    low_cnt = 0; ok_cnt = 0; ok_idx = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus_if.lane_rst_n == 3'b011) low_cnt++;
      if (bus_if.recover_ok) begin ok_cnt++; ok_idx = i; end
      if (i == 25) begin bus_if.fault_flags = 3'b000; bus_if.disagreement = 1'b1; end
      if (i == 27) bus_if.disagreement = 1'b0;
    end
    check("t3_low_cycles", low_cnt, 16);
    check("t3_ok_cnt", ok_cnt, 1);
    check("t3_ok_idx", ok_idx, 28);
    check("t3_busy", bus_if.busy, 0);
    check("t3_failed", bus_if.lane_failed, 0);
    check("t3_fault_cnt", bus_if.fault_cnt, 24'h010100);

    // Lane 0 never recovers: three attempts, then retired.
    bus_if.fault_flags = 3'b001;
    low_cnt = 0; fail_cnt = 0; fail_idx = 0; bad_cnt = 0;
    for (int i = 1; i <= 260; i++) begin
      @(negedge clk);
      if (bus_if.lane_rst_n == 3'b110) low_cnt++;
      else if (bus_if.lane_rst_n != 3'b111) bad_cnt++;
      if (bus_if.recover_fail) begin fail_cnt++; fail_idx = i; end
    end
    check("t4_low_cycles", low_cnt, 48);
    check("t4_other_lane", bad_cnt, 0);
    check("t4_fail_cnt", fail_cnt, 1);
    check("t4_fail_idx", fail_idx, 244);
    check("t4_failed", bus_if.lane_failed, 3'b001);
    check("t4_idle", bus_if.busy, 0);
    check("t4_fault_cnt", bus_if.fault_cnt, 24'h010101);
    bus_if.clear_failed = 1'b1;
    cyc(1);
    bus_if.clear_failed = 1'b0;
    check("t4_clr_failed", bus_if.lane_failed, 0);
    check("t4_clr_cnt", bus_if.fault_cnt, 0);
    cyc(4);
    check("t4_requal_rst", bus_if.lane_rst_n, 3'b110);
    check("t4_requal_cnt", bus_if.fault_cnt, 24'h000001);
    bus_if.fault_flags = 3'b000;
    wait_idle(40);
    cyc(1);

    // No majority: two lanes flagged.
    bus_if.fault_flags = 3'b011;
    bad_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.busy || bus_if.lane_rst_n != 3'b111) bad_cnt++;
    end
    check("t5_no_action", bad_cnt, 0);
    bus_if.fault_flags = 3'b000;
    cyc(1);

    // Asynchronous reset during HOLD.
    bus_if.fault_flags = 3'b010;
    cyc(6);
    check("t6_in_hold", bus_if.lane_rst_n, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_lane_rst_n", bus_if.lane_rst_n, 3'b111);
    check("t6_rst_busy", bus_if.busy, 0);
    check("t6_rst_active", bus_if.active_lane, 2'd3);
    check("t6_rst_cnt", bus_if.fault_cnt, 0);
    bus_if.fault_flags = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Counter saturation on lane 1.
    for (int n = 0; n < 255; n++) run_seq(3'b010);
    check("t7_cnt_ff", bus_if.fault_cnt, 24'h00FF00);
    run_seq(3'b010);
    check("t7_cnt_sat", bus_if.fault_cnt, 24'h00FF00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tmr_recovery_sequencer.md
Name: tmr_recovery_sequencer

Overview:
Controller that watches the TMR voter's per-lane fault flags and sequences recovery of a single faulty lane.
- Qualifies persistent single-lane faults.
- Holds the faulty lane's core in reset, then waits for it to re-agree with the majority.
- Retries a bounded number of times, then retires the lane.
- Sits between the voter and the per-lane core reset inputs; its counters and status feed the LED/status output logic.

Parameters:
PERSIST_CYCLES, 4, consecutive identical samples needed to qualify a fault (>=1)
RESET_HOLD, 16, cycles lane_rst_n is held low per attempt (>=1)
SETTLE_MAX, 64, cycles allowed after release for the lane to re-agree (>=1)
MAX_RETRIES, 3, reset attempts before a lane is declared failed (>=1)
CNT_W, 8, width of each per-lane fault event counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  when 0, no new fault is qualified; a sequence already in progress completes
fault_flags  in  3  voter per-lane mismatch flags, bit i = lane i disagrees with majority
disagreement  in  1  voter any-mismatch flag
clear_failed  in  1  single-cycle pulse: clears lane_failed and all fault counters
lane_rst_n  out  3  active-low reset to each lane's core
busy  out  1  high in any state other than IDLE
active_lane  out  2  index of the lane under recovery; 2'd3 when IDLE
lane_failed  out  3  sticky per-lane retired flags
fault_cnt  out  3*CNT_W  per-lane qualified-fault counters, lane i at [i*CNT_W +: CNT_W]
recover_ok  out  1  one-cycle pulse on successful recovery
recover_fail  out  1  one-cycle pulse when a lane is retired

Behaviour:
- Reset values: state IDLE, lane_rst_n=3'b111, busy=0, active_lane=2'd3, lane_failed=0, fault_cnt=0, recover_ok=0, recover_fail=0, internal timers and retry count 0.
- All outputs are registered.
- A "candidate" is a one-hot fault_flags naming lane L with lane_failed[L]=0.
- IDLE:
  - On enable=1 and a candidate: latch L, set persist=1, go to QUALIFY.
  - Multi-bit fault_flags (no majority) or a flag on a failed lane: no action, stay IDLE.
  - If PERSIST_CYCLES=1: go directly to HOLD and count the fault.
- QUALIFY:
  - fault_flags equal to the latched one-hot increments persist.
  - Any other value returns to IDLE with no count (transient).
  - When persist reaches PERSIST_CYCLES:
    - fault_cnt[L] increments, saturating at all-ones.
    - retry count clears.
    - go to HOLD.
  - Latency: first sample at cycle t0 -> lane_rst_n[L]=0 visible at t0+PERSIST_CYCLES.
- HOLD:
  - lane_rst_n[L]=0 for exactly RESET_HOLD cycles; other lanes stay 1.
  - Then go to SETTLE with lane_rst_n[L]=1.
- SETTLE:
  - Timer counts from 1.
  - First cycle with fault_flags[L]=0 and disagreement=0: recover_ok pulses next cycle, then return to IDLE.
  - If the timer reaches SETTLE_MAX without that condition, retry increments:
    - retry < MAX_RETRIES: back to HOLD.
    - retry = MAX_RETRIES: set lane_failed[L], pulse recover_fail, return to IDLE.
  - Success and timeout on the same cycle: success wins.
- Flags on other lanes during QUALIFY/HOLD/SETTLE are ignored; they are re-evaluated from IDLE.
- Only one lane is ever in reset.
- A lane with lane_failed set is never reset again until clear_failed.
- clear_failed:
  - Clears lane_failed and fault_cnt in any state.
  - Does not abort an in-progress sequence.
  - If it coincides with a fault_cnt increment or a lane_failed set, the clear wins.
- enable deasserted mid-sequence: the sequence completes normally.
- Asynchronous rst_n mid-sequence: immediate return to reset values; lane_rst_n is released to 3'b111.

Test Plan:
- fault_flags=3'b010 held 4 cycles from t0 (defaults) -> lane_rst_n=3'b101 from t0+4 for 16 cycles; fault_cnt lane1=1; busy=1, active_lane=1 throughout.
- fault_flags=3'b001 for 3 cycles then 0 -> no reset asserted, fault_cnt unchanged, back to IDLE.
- Lane 2 fault qualified, flags clear 5 cycles after release -> recover_ok single pulse, busy=0, lane_failed=0.
- Lane 0 fault persists forever -> 3 hold/settle cycles of 16+64, then lane_failed=3'b001 and a recover_fail pulse; a further 3'b001 causes no reset; clear_failed then re-enables qualification.
- fault_flags=3'b011 for 20 cycles -> stays IDLE, no reset.
- rst_n asserted during HOLD -> lane_rst_n=3'b111 and all outputs at reset values immediately.
- fault_cnt at 8'hFF with another qualification -> stays 8'hFF.
